// File: rtl/alu_pkg.sv
// Shared encodings for the ALU/MDU block: ALUFun groups and sub-codes, MdOp classes, FSM states.
package alu_pkg;

  localparam logic [1:0] GRP_ARITH = 2'b00;
  localparam logic [1:0] GRP_LOGIC = 2'b01;
  localparam logic [1:0] GRP_SHIFT = 2'b10;
  localparam logic [1:0] GRP_CMP   = 2'b11;

  localparam logic [3:0] LOG_AND   = 4'b1000;
  localparam logic [3:0] LOG_OR    = 4'b1110;
  localparam logic [3:0] LOG_XOR   = 4'b0110;
  localparam logic [3:0] LOG_NOR   = 4'b0001;
  localparam logic [3:0] LOG_PASSA = 4'b1010;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b11;

  localparam logic [2:0] CMP_NE  = 3'b000;
  localparam logic [2:0] CMP_EQ  = 3'b001;
  localparam logic [2:0] CMP_LT  = 3'b010;
  localparam logic [2:0] CMP_LTZ = 3'b101;
  localparam logic [2:0] CMP_LEZ = 3'b110;
  localparam logic [2:0] CMP_GTZ = 3'b111;

  typedef enum logic [1:0] {
    MD_ALU   = 2'b00,
    MD_MULLO = 2'b01,
    MD_MULHI = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational ALU: arithmetic, logic, shift and compare groups.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       alu_fun,
  input  logic             sign,
  output logic [WIDTH-1:0] z
);
  localparam int SHAMT_W = $clog2(WIDTH);

  logic [SHAMT_W-1:0] shamt;
  logic               lt, ltz, lez, gtz, flag;

  assign shamt = a[SHAMT_W-1:0];

  always_comb begin
    lt   = sign ? ($signed(a) < $signed(b)) : (a < b);
    ltz  = sign & a[WIDTH-1];
    lez  = ltz | (a == '0);
    gtz  = ~lez;
    flag = 1'b0;
    case (alu_fun[3:1])
      CMP_EQ:  flag = (a == b);
      CMP_NE:  flag = (a != b);
      CMP_LT:  flag = lt;
      CMP_LEZ: flag = lez;
      CMP_LTZ: flag = ltz;
      CMP_GTZ: flag = gtz;
      default: flag = 1'b0;
    endcase

    z = '0;
    case (alu_fun[5:4])
      GRP_ARITH: z = alu_fun[0] ? (a - b) : (a + b);
      GRP_LOGIC: begin
        case (alu_fun[3:0])
          LOG_AND:   z = a & b;
          LOG_OR:    z = a | b;
          LOG_XOR:   z = a ^ b;
          LOG_NOR:   z = ~(a | b);
          LOG_PASSA: z = a;
          default:   z = '0;
        endcase
      end
      GRP_SHIFT: begin
        case (alu_fun[1:0])
          SH_SLL:  z = b << shamt;
          SH_SRL:  z = b >> shamt;
          SH_SRA:  z = WIDTH'($signed(b) >>> shamt);
          default: z = '0;
        endcase
      end
      default: z = {{(WIDTH-1){1'b0}}, flag};
    endcase
  end

endmodule

// File: rtl/alu_mdu.sv
// ALU plus iterative multiply/divide unit with valid/ready handshake on both sides.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       ALUFun,
  input  logic [1:0]       MdOp,
  input  logic             Sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] R
);
  localparam int SHAMT_W = $clog2(WIDTH);

  state_e               state;
  logic [WIDTH-1:0]     a_q, md, lo, acc;
  logic [SHAMT_W-1:0]   cnt;
  logic                 is_hi, neg_z, neg_r, div_zero;
  logic                 accept, last;
  logic [WIDTH-1:0]     alu_z, abs_a, abs_b;
  logic [WIDTH:0]       mul_sum, rem_sh, diff;
  logic [WIDTH-1:0]     step_acc, step_lo, q_fix, r_fix;
  logic [2*WIDTH-1:0]   prod, prod_fix;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a       (A),
    .b       (B),
    .alu_fun (ALUFun),
    .sign    (Sign),
    .z       (alu_z)
  );

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign last      = (cnt == SHAMT_W'(WIDTH-1));
  assign abs_a     = (Sign & A[WIDTH-1]) ? -A : A;
  assign abs_b     = (Sign & B[WIDTH-1]) ? -B : B;

  // Magnitudes are iterated unsigned; signs are re-applied on the final step.
  always_comb begin
    mul_sum = {1'b0, acc} + {1'b0, md & {WIDTH{lo[0]}}};
    rem_sh  = {acc, lo[WIDTH-1]};
    diff    = rem_sh - {1'b0, md};
    if (state == DIV) begin
      step_acc = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      step_lo  = {lo[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      step_acc = mul_sum[WIDTH:1];
      step_lo  = {mul_sum[0], lo[WIDTH-1:1]};
    end
    prod     = {step_acc, step_lo};
    prod_fix = neg_z ? -prod : prod;
    q_fix    = neg_z ? -step_lo : step_lo;
    r_fix    = neg_r ? -step_acc : step_acc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      Z        <= '0;
      R        <= '0;
      a_q      <= '0;
      md       <= '0;
      lo       <= '0;
      acc      <= '0;
      cnt      <= '0;
      is_hi    <= 1'b0;
      neg_z    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        MUL, DIV: begin
          acc <= step_acc;
          lo  <= step_lo;
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            cnt   <= '0;
            if (state == MUL) begin
              Z <= is_hi ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
              R <= '0;
            end else if (div_zero) begin
              Z <= '1;
              R <= a_q;
            end else begin
              Z <= q_fix;
              R <= r_fix;
            end
          end
        end
        DONE: if (out_ready & ~accept) state <= IDLE;
        default: ;
      endcase

      // Accept only happens in IDLE/DONE, so it never collides with an iteration.
      if (accept) begin
        cnt      <= '0;
        acc      <= '0;
        a_q      <= A;
        is_hi    <= (MdOp == MD_MULHI);
        div_zero <= (B == '0);
        neg_z    <= Sign & (A[WIDTH-1] ^ B[WIDTH-1]);
        neg_r    <= Sign & A[WIDTH-1];
        case (MdOp)
          MD_ALU: begin
            Z     <= alu_z;
            R     <= '0;
            state <= DONE;
          end
          MD_DIV: begin
            lo    <= abs_a;
            md    <= abs_b;
            state <= DIV;
          end
          default: begin
            lo    <= abs_b;
            md    <= abs_a;
            state <= MUL;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed scoreboard bench for alu_mdu at WIDTH=32.
module tb_alu_mdu;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [5:0]   ALUFun = '0;
  logic [1:0]   MdOp = '0;
  logic         Sign = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] Z;
  logic [W-1:0] R;

  typedef struct {
    logic [W-1:0] z;
    logic [W-1:0] r;
    int           lat;
    int           t0;
    string        tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  alu_mdu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ALUFun    (ALUFun),
    .MdOp      (MdOp),
    .Sign      (Sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Z         (Z),
    .R         (R)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [W-1:0] ez, input logic [W-1:0] er, input int lat);
    exp_t e;
    e.z = ez; e.r = er; e.lat = lat; e.t0 = cyc; e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Called at a negedge while the block is idle; returns at the negedge after accept.
  task automatic issue(input string tag, input logic [1:0] op, input logic [5:0] fun, input logic sg,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ez, input logic [W-1:0] er, input int lat);
    check({tag, " in_ready"}, in_ready, 1);
    MdOp = op; ALUFun = fun; Sign = sg; A = a; B = b; in_valid = 1'b1;
    push(tag, ez, er, lat);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_head();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard underflow", exp_q.size(), 1);
      return;
    end
    e = exp_q.pop_front();
    check({e.tag, " out_valid"}, out_valid, 1);
    if (e.lat > 0) check({e.tag, " latency"}, cyc - e.t0, e.lat);
    check({e.tag, " Z"}, Z, e.z);
    check({e.tag, " R"}, R, e.r);
  endtask

  task automatic collect(input int hold);
    logic [W-1:0] z0;
    int n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    z0 = exp_q.size() > 0 ? exp_q[0].z : '0;
    check_head();
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check("hold out_valid", out_valid, 1);
      check("hold Z", Z, z0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("released out_valid", out_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    repeat (2) @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset Z", Z, 0);
    check("reset R", R, 0);
    check("reset in_ready", in_ready, 1);
    reset = 1'b0;
    @(negedge clk);

    // ALU group
    issue("sub",   MD_ALU, 6'b000001, 1, 32'd5, 32'd7, 32'hFFFFFFFE, 0, 1);      collect(3);
    issue("addwr", MD_ALU, 6'b000000, 0, 32'hFFFFFFFF, 32'd1, 32'h0, 0, 1);     collect(0);
    issue("sra",   MD_ALU, 6'b100011, 0, 32'd4, 32'h80000000, 32'hF8000000, 0, 1); collect(0);
    issue("srl",   MD_ALU, 6'b100001, 0, 32'd4, 32'h80000000, 32'h08000000, 0, 1); collect(0);
    issue("sll",   MD_ALU, 6'b100000, 0, 32'd36, 32'd1, 32'h10, 0, 1);          collect(0);
    issue("sh10",  MD_ALU, 6'b100010, 0, 32'd4, 32'h80000000, 32'h0, 0, 1);    collect(0);
    issue("and",   MD_ALU, 6'b011000, 0, 32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F, 0, 1); collect(0);
    issue("or",    MD_ALU, 6'b011110, 0, 32'hF0F000FF, 32'h0FF00F0F, 32'hFFF00FFF, 0, 1); collect(0);
    issue("xor",   MD_ALU, 6'b010110, 0, 32'hF0F000FF, 32'h0FF00F0F, 32'hFF000FF0, 0, 1); collect(0);
    issue("nor",   MD_ALU, 6'b010001, 0, 32'hF0F000FF, 32'h0FF00F0F, 32'h000FF000, 0, 1); collect(0);
    issue("passa", MD_ALU, 6'b011010, 0, 32'h12345678, 32'h0, 32'h12345678, 0, 1); collect(0);
    issue("logbad",MD_ALU, 6'b011111, 0, 32'hF0F000FF, 32'h0FF00F0F, 32'h0, 0, 1); collect(0);
    issue("slt_s", MD_ALU, 6'b110100, 1, 32'hFFFFFFFF, 32'd1, 32'd1, 0, 1);     collect(0);
    issue("slt_u", MD_ALU, 6'b110100, 0, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 1);     collect(0);
    issue("eq",    MD_ALU, 6'b110010, 0, 32'd5, 32'd5, 32'd1, 0, 1);            collect(0);
    issue("ne",    MD_ALU, 6'b110000, 0, 32'd5, 32'd5, 32'd0, 0, 1);            collect(0);
    issue("gtz_s", MD_ALU, 6'b111110, 1, 32'h80000000, 32'd0, 32'd0, 0, 1);     collect(0);
    issue("gtz_u", MD_ALU, 6'b111110, 0, 32'h80000000, 32'd0, 32'd1, 0, 1);     collect(0);
    issue("ltz_s", MD_ALU, 6'b111010, 1, 32'h80000000, 32'd0, 32'd1, 0, 1);     collect(0);
    issue("lez_u", MD_ALU, 6'b111100, 0, 32'd0, 32'd0, 32'd1, 0, 1);            collect(0);

    // MUL / DIV
    issue("mulhi_s", MD_MULHI, 6'b0, 1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 0, 33); collect(0);
    issue("mulhi_u", MD_MULHI, 6'b0, 0, 32'hFFFFFFFF, 32'd2, 32'h1, 0, 33);        collect(0);
    issue("mullo_s", MD_MULLO, 6'b0, 1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 0, 33); collect(0);
    issue("div_s",   MD_DIV, 6'b0, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33); collect(0);
    issue("div_sb",  MD_DIV, 6'b0, 1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 33); collect(0);
    issue("div_u",   MD_DIV, 6'b0, 0, 32'd100, 32'd7, 32'd14, 32'd2, 33);          collect(0);
    issue("div0",    MD_DIV, 6'b0, 1, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9, 33);      collect(0);
    issue("divmin",  MD_DIV, 6'b0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 33); collect(0);

    // back-to-back ALU issue with out_ready held high
    out_ready = 1'b1; in_valid = 1'b1; MdOp = MD_ALU; ALUFun = 6'b000000; Sign = 1'b0;
    for (int i = 0; i < 4; i++) begin
      A = 32'(100 * i + 3); B = 32'(i + 1);
      check("b2b in_ready", in_ready, 1);
      push("b2b", 32'(100 * i + 3 + i + 1), 32'd0, 1);
      @(negedge clk);
      check_head();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b drain", out_valid, 0);
    out_ready = 1'b0;

    // in_valid ignored while a multiply is iterating
    issue("mul_busy", MD_MULLO, 6'b0, 0, 32'd3, 32'd5, 32'd15, 0, 33);
    in_valid = 1'b1; MdOp = MD_ALU; ALUFun = 6'b000000; A = 32'h1111; B = 32'h2222;
    repeat (5) begin
      check("busy in_ready", in_ready, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    collect(0);

    // reset in the middle of a divide
    issue("div_rst", MD_DIV, 6'b0, 0, 32'd1000, 32'd3, 32'd333, 32'd1, 0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst out_valid", out_valid, 0);
    check("midrst Z", Z, 0);
    exp_q.delete();
    reset = 1'b0;
    @(negedge clk);
    check("midrst in_ready", in_ready, 1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst no output", seen, 0);
    issue("post_rst", MD_ALU, 6'b000000, 0, 32'd2, 32'd3, 32'd5, 0, 1);
    collect(0);

    check("scoreboard empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the datapath width; legal values are powers of two from 8 to 64.
REQ-002 SHALL have derived constant SHAMT_W = log2(WIDTH), meaning the shift-amount width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  the operation request is valid.
REQ-006 SHALL have port in_ready  output  1  the block accepts a request this cycle.
REQ-007 SHALL have port A  input  WIDTH  operand A; also the shift amount for shift ops.
REQ-008 SHALL have port B  input  WIDTH  operand B; also the shifted value for shift ops.
REQ-009 SHALL have port ALUFun  input  6  single-cycle ALU function, used when MdOp=00.
REQ-010 SHALL have port MdOp  input  2  operation class: 00 ALU, 01 MULLO, 10 MULHI, 11 DIV.
REQ-011 SHALL have port Sign  input  1  signed (1) or unsigned (0) interpretation.
REQ-012 SHALL have port out_valid  output  1  the result is valid.
REQ-013 SHALL have port out_ready  input  1  the consumer takes the result.
REQ-014 SHALL have port Z  output  WIDTH  primary result.
REQ-015 SHALL have port R  output  WIDTH  remainder for DIV; zero for all other ops.

Function
REQ-016 SHALL accept a request only on a cycle where in_valid and in_ready are both high; operands and op are captured in that cycle.
REQ-017 SHALL assert in_ready only in IDLE, or in DONE when out_ready is high (back-to-back issue).
REQ-018 SHALL implement FSM states IDLE, MUL, DIV, DONE: IDLE->DONE on an ALU op; IDLE->MUL on MULLO/MULHI; IDLE->DIV on DIV; MUL/DIV->DONE after exactly WIDTH iteration cycles; DONE->IDLE on out_ready without a new accept; DONE->next state on out_ready with a new accept.
REQ-019 SHALL give ALU ops a latency of 1 cycle (out_valid in the cycle after accept), and MUL/DIV ops a latency of WIDTH+1 cycles.
REQ-020 SHALL assert out_valid exactly in DONE and hold Z and R stable until out_ready is sampled high.
REQ-021 SHALL decode ALUFun[5:4]=00 as add (ALUFun[0]=0) or subtract A-B (ALUFun[0]=1), modulo 2^WIDTH.
REQ-022 SHALL decode ALUFun[5:4]=01 on ALUFun[3:0]: 1000 AND, 1110 OR, 0110 XOR, 0001 NOR, 1010 pass A; other codes give 0.
REQ-023 SHALL decode ALUFun[5:4]=10 on ALUFun[1:0] with amount A[SHAMT_W-1:0] applied to B: 00 SLL, 01 SRL, 11 SRA (fills with B[WIDTH-1]); 10 gives 0.
REQ-024 SHALL decode ALUFun[5:4]=11 on ALUFun[3:1], placing the 1-bit result in Z[0] with other bits zero: 001 A==B, 000 A!=B, 010 A<B (signed or unsigned per Sign), 110 A<=0, 101 A<0, 111 A>0; the last three use signed A when Sign=1 and unsigned A when Sign=0; other codes give 0.
REQ-025 SHALL give MULLO the low WIDTH bits and MULHI the high WIDTH bits of the 2*WIDTH-bit product, signed when Sign=1, via iterative shift-add, one partial product per cycle.
REQ-026 SHALL compute DIV as a truncating quotient in Z and a remainder in R (sign of R follows A), via restoring division, one quotient bit per cycle.
REQ-027 SHALL handle division by zero as Z = all ones, R = A.
REQ-028 SHALL handle signed MIN/-1 as Z = MIN, R = 0.
REQ-029 SHALL ignore in_valid while in MUL or DIV, with in_ready low; captured operands are not altered by input changes.

Reset
REQ-030 SHALL on reset, at any time including mid-iteration, force state IDLE, out_valid=0, Z=0, R=0, all iteration counters and partial registers to 0, and in_ready=1 once reset deasserts; any in-flight op is discarded without producing output.

Structure
REQ-031 SHALL place the ALUFun group and sub-codes, the MdOp codes, and the FSM state enumeration in a shared package alu_pkg.
REQ-032 SHALL implement the single-cycle datapath (REQ-021..REQ-024) as the combinational sub-module alu_core, parametrised by WIDTH; alu_mdu contains the FSM, the handshake and the iterative MUL/DIV datapath.

Verification
REQ-033 SHALL verify: WIDTH=32, ALUFun=000001, A=5, B=7, Sign=1 -> Z=0xFFFFFFFE one cycle after accept, and out_valid is held while out_ready=0.
REQ-034 SHALL verify: ALUFun=100011, A=4, B=0x80000000 -> Z=0xF8000000; with ALUFun=100001 -> Z=0x08000000.
REQ-035 SHALL verify: MULHI, Sign=1, A=0xFFFFFFFF, B=2 -> Z=0xFFFFFFFF at 33 cycles after accept; with Sign=0 -> Z=1.
REQ-036 SHALL verify: DIV, Sign=1, A=-7, B=2 -> Z=-3, R=-1; DIV with B=0 and A=9 -> Z=0xFFFFFFFF, R=9; DIV with A=0x80000000, B=-1 -> Z=0x80000000, R=0.
REQ-037 SHALL verify: reset asserted at iteration 10 of a DIV -> out_valid stays 0, in_ready=1 after release, and the next ALU op completes correctly.
REQ-038 SHALL verify: back-to-back ALU ops with out_ready held high -> one result per cycle, and in_valid is ignored during a MUL.
